// File: rtl/cpu_datapath.sv
// cpu_datapath: 8-bit accumulator-machine datapath that executes one
// 16-bit control word per clock and returns the current opcode.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   RUN                 1 = execute ctrl_wrd, 0 = treat it as all-zero
//   ctrl_wrd[15:0]      HLT AI AO BI MI RR RW II IO CI CO CE ALUOPTION ALUO DI FL
//   prog_we/addr/data   RAM loader, honoured only while stopped or halted
//   command             IR opcode field IR[7:4]
//   bus                 internal bus value
//   disp_out            display register
//   a_out, b_out        A and B registers
//   pc_out              program counter
//   flag_c, flag_z      carry / zero flags, updated on FL
//   halted, bus_err     sticky halt and sticky bus-contention flags
module cpu_datapath #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int OP_W   = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              RUN,
   input  logic [15:0]       ctrl_wrd,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [OP_W-1:0]   command,
   output logic [DATA_W-1:0] bus,
   output logic [DATA_W-1:0] disp_out,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              flag_c,
   output logic              flag_z,
   output logic              halted,
   output logic              bus_err
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [15:0]       eff;
   logic              hlt, ai, ao, bi, mi, rr, rw, ii;
   logic              io, ci, co, ce, alu_sub, aluo, di, fl;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [DATA_W-1:0] b_opnd;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu;
   logic [4:0]        drv;
   logic              multi;
   logic              prog_en;

   // Once halted the machine ignores the sequencer entirely.
   assign eff = (RUN && !halted) ? ctrl_wrd : 16'h0000;

   assign hlt     = eff[15];
   assign ai      = eff[14];
   assign ao      = eff[13];
   assign bi      = eff[12];
   assign mi      = eff[11];
   assign rr      = eff[10];
   assign rw      = eff[9];
   assign ii      = eff[8];
   assign io      = eff[7];
   assign ci      = eff[6];
   assign co      = eff[5];
   assign ce      = eff[4];
   assign alu_sub = eff[3];
   assign aluo    = eff[2];
   assign di      = eff[1];
   assign fl      = eff[0];

   // Subtract as A + ~B + 1, so carry-out means "no borrow".
   assign b_opnd = alu_sub ? ~b_out : b_out;
   assign sum    = {1'b0, a_out}
                 + {1'b0, b_opnd}
                 + {{DATA_W{1'b0}}, alu_sub};
   assign alu    = sum[DATA_W-1:0];

   assign command = ir[DATA_W-1 -: OP_W];

   // x & (x-1) is nonzero exactly when two or more drivers are on.
   assign drv   = {ao, rr, io, co, aluo};
   assign multi = |(drv & (drv - 5'd1));

   always_comb begin
      bus = '0;
      case (drv)
         5'b10000: bus = a_out;
         5'b01000: bus = mem[mar];
         5'b00100: bus = {{OP_W{1'b0}}, ir[DATA_W-OP_W-1:0]};
         5'b00010: bus = {{(DATA_W-ADDR_W){1'b0}}, pc_out};
         5'b00001: bus = alu;
         default:  bus = '0;
      endcase
   end

   assign prog_en = prog_we && (!RUN || halted);

   // RAM is deliberately not reset; loader write beats a bus write.
   always_ff @(posedge CLK) begin
      if (prog_en)
         mem[prog_addr] <= prog_data;
      else if (rw)
         mem[mar] <= bus;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         a_out    <= '0;
         b_out    <= '0;
         ir       <= '0;
         disp_out <= '0;
         pc_out   <= '0;
         mar      <= '0;
         flag_c   <= 1'b0;
         flag_z   <= 1'b0;
         halted   <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         if (ai) a_out    <= bus;
         if (bi) b_out    <= bus;
         if (ii) ir       <= bus;
         if (di) disp_out <= bus;
         if (mi) mar      <= bus[ADDR_W-1:0];
         if (ci)
            pc_out <= bus[ADDR_W-1:0];
         else if (ce)
            pc_out <= pc_out + ADDR_W'(1);
         if (fl) begin
            flag_c <= sum[DATA_W];
            flag_z <= (alu == '0);
         end
         if (hlt)   halted  <= 1'b1;
         if (multi) bus_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed program for cpu_datapath checked against an
// instruction-level model every cycle plus hand-computed expectations.
module tb_cpu_datapath;

   localparam logic [15:0] HLT  = 16'h8000;
   localparam logic [15:0] AI   = 16'h4000;
   localparam logic [15:0] AO   = 16'h2000;
   localparam logic [15:0] BI   = 16'h1000;
   localparam logic [15:0] MI   = 16'h0800;
   localparam logic [15:0] RR   = 16'h0400;
   localparam logic [15:0] RW   = 16'h0200;
   localparam logic [15:0] II   = 16'h0100;
   localparam logic [15:0] IO   = 16'h0080;
   localparam logic [15:0] CI   = 16'h0040;
   localparam logic [15:0] CO   = 16'h0020;
   localparam logic [15:0] CE   = 16'h0010;
   localparam logic [15:0] SUB  = 16'h0008;
   localparam logic [15:0] ALUO = 16'h0004;
   localparam logic [15:0] DI   = 16'h0002;
   localparam logic [15:0] FL   = 16'h0001;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        RUN = 1'b0;
   logic [15:0] ctrl_wrd = '0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [7:0]  prog_data = '0;
   logic [3:0]  command;
   logic [7:0]  bus, disp_out, a_out, b_out;
   logic [3:0]  pc_out;
   logic        flag_c, flag_z, halted, bus_err;

   int asserts = 0;
   int fails   = 0;

   // Model state as plain integers.
   int m_a = 0, m_b = 0, m_pc = 0, m_mar = 0, m_ir = 0, m_disp = 0;
   int m_c = 0, m_z = 0, m_halt = 0, m_err = 0;
   int m_ram [16];

   cpu_datapath dut (
      .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .ctrl_wrd(ctrl_wrd),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .command(command), .bus(bus), .disp_out(disp_out),
      .a_out(a_out), .b_out(b_out), .pc_out(pc_out),
      .flag_c(flag_c), .flag_z(flag_z),
      .halted(halted), .bus_err(bus_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   function automatic logic [15:0] m_eff();
      return (RUN && m_halt == 0) ? ctrl_wrd : 16'h0000;
   endfunction

   // ALU result as integers: subtract is A + 256 - B.
   function automatic int m_sum();
      logic [15:0] w;
      w = m_eff();
      return (w & SUB) != 0 ? m_a + 256 - m_b : m_a + m_b;
   endfunction

   // Bus value: the single enabled source, else 0; n = number of sources.
   task automatic m_bus(output int v, output int n);
      logic [15:0] w;
      w = m_eff();
      v = 0;
      n = 0;
      if ((w & AO) != 0)   begin n++; v = m_a; end
      if ((w & RR) != 0)   begin n++; v = m_ram[m_mar]; end
      if ((w & IO) != 0)   begin n++; v = m_ir % 16; end
      if ((w & CO) != 0)   begin n++; v = m_pc; end
      if ((w & ALUO) != 0) begin n++; v = m_sum() % 256; end
      if (n != 1) v = 0;
   endtask

   always @(posedge CLK or negedge RST_N) begin
      logic [15:0] w;
      int v, n, s;
      if (!RST_N) begin
         m_a = 0; m_b = 0; m_pc = 0; m_mar = 0; m_ir = 0; m_disp = 0;
         m_c = 0; m_z = 0; m_halt = 0; m_err = 0;
      end else begin
         w = m_eff();
         m_bus(v, n);
         s = m_sum();
         if (prog_we && (!RUN || m_halt != 0))
            m_ram[prog_addr] = prog_data;
         else if ((w & RW) != 0)
            m_ram[m_mar] = v;
         if ((w & AI) != 0) m_a = v;
         if ((w & BI) != 0) m_b = v;
         if ((w & II) != 0) m_ir = v;
         if ((w & DI) != 0) m_disp = v;
         if ((w & MI) != 0) m_mar = v % 16;
         if ((w & CI) != 0)      m_pc = v % 16;
         else if ((w & CE) != 0) m_pc = (m_pc + 1) % 16;
         if ((w & FL) != 0) begin
            m_c = s > 255 ? 1 : 0;
            m_z = (s % 256) == 0 ? 1 : 0;
         end
         if ((w & HLT) != 0) m_halt = 1;
         if (n > 1) m_err = 1;
      end
   end

   always @(negedge CLK) begin
      int v, n;
      m_bus(v, n);
      chk("bus",      bus,      v);
      chk("command",  command,  m_ir / 16);
      chk("a_out",    a_out,    m_a);
      chk("b_out",    b_out,    m_b);
      chk("pc_out",   pc_out,   m_pc);
      chk("disp_out", disp_out, m_disp);
      chk("flag_c",   flag_c,   m_c);
      chk("flag_z",   flag_z,   m_z);
      chk("halted",   halted,   m_halt);
      chk("bus_err",  bus_err,  m_err);
   end

   task automatic step(input logic [15:0] cw);
      @(negedge CLK);
      #2;
      ctrl_wrd = cw;
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input int ad, input int d);
      @(negedge CLK);
      #2;
      ctrl_wrd  = '0;
      prog_we   = 1'b1;
      prog_addr = 4'(ad);
      prog_data = 8'(d);
      @(posedge CLK);
      #1;
      prog_we = 1'b0;
   endtask

   task automatic fetch_exec(input logic [15:0] ld);
      step(CO | MI);
      step(RR | II | CE);
      step(IO | MI);
      step(RR | ld);
   endtask

   initial begin
      int img [16];
      img = '{8'h13, 8'h1D, 8'h2E, 8'h42, 8'h00, 8'h00, 8'h00, 8'h85,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h20, 8'h00};
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_a",   a_out,   8'h00);
      chk("rst_pc",  pc_out,  4'h0);
      chk("rst_err", bus_err, 1'b0);
      @(negedge CLK);
      #2;
      RST_N = 1'b1;

      for (int i = 0; i < 16; i++) load(i, img[i]);

      RUN = 1'b1;
      fetch_exec(AI);
      chk("lda_cmd", command, 4'h1);
      chk("lda_pc",  pc_out,  4'h1);
      chk("lda_a",   a_out,   8'h42);

      RUN = 1'b0;
      step(AI | AO);
      chk("gate_a",   a_out,   8'h42);
      chk("gate_err", bus_err, 1'b0);
      chk("gate_bus", bus,     8'h00);
      RUN = 1'b1;

      fetch_exec(AI);
      fetch_exec(BI);
      chk("ldb_b", b_out, 8'h20);
      step(ALUO | AI | FL);
      chk("add_a", a_out,  8'h10);
      chk("add_c", flag_c, 1'b1);
      chk("add_z", flag_z, 1'b0);
      step(AO | BI);
      step(SUB | ALUO | AI | FL);
      chk("sub_a", a_out,  8'h00);
      chk("sub_c", flag_c, 1'b1);
      chk("sub_z", flag_z, 1'b1);

      repeat (12) step(CE);
      chk("pc_15", pc_out, 4'hF);
      step(CE);
      chk("pc_wrap", pc_out, 4'h0);
      repeat (7) step(CE);
      step(CO | MI);
      step(RR | II);
      chk("ir_cmd", command, 4'h8);
      step(IO | CI | CE);
      chk("ci_wins", pc_out, 4'h5);
      step(RR | AI);

      step(AO | CO);
      chk("cont_bus", bus,     8'h00);
      chk("cont_err", bus_err, 1'b1);
      chk("cont_a",   a_out,   8'h85);
      step(16'h0000);
      chk("err_sticky", bus_err, 1'b1);

      step(HLT | AO | DI);
      chk("hlt_disp", disp_out, 8'h85);
      chk("hlt_flag", halted,   1'b1);
      step(RR | AI);
      chk("hlt_a", a_out, 8'h85);
      load(7, 8'h5A);

      @(negedge CLK);
      #2;
      RST_N = 1'b0;
      @(negedge CLK);
      #2;
      RST_N = 1'b1;
      repeat (7) step(CE);
      step(CO | MI);
      step(RR | AI);
      chk("ram_kept_a", a_out,  8'h5A);
      chk("ram_kept_pc", pc_out, 4'h7);

      #2;
      ctrl_wrd = '0;
      RST_N = 1'b0;
      #1;
      chk("async_a",   a_out,   8'h00);
      chk("async_pc",  pc_out,  4'h0);
      chk("async_hlt", halted,  1'b0);
      chk("async_cmd", command, 4'h0);
      @(negedge CLK);
      #2;
      RST_N = 1'b1;

      load(0, 8'hEE);
      step(RR | AI);
      chk("run_we_ignored", a_out, 8'h13);

      repeat (2) @(negedge CLK);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               asserts, fails);
      $finish;
   end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Executes the 16-bit control word issued each cycle by the control sequencer.
- Holds the 8-bit machine state: A, B, PC, MAR, IR, 16x8 RAM, ALU, display register, flags.
- Closes the loop by returning the current opcode as `command` = IR[7:4].
- Includes a program-load port so RAM can be filled before the machine runs.

Parameters:
- DATA_W, 8, bus / register / RAM word width
- ADDR_W, 4, PC and MAR width; RAM depth is 2**ADDR_W
- OP_W, 4, opcode width (IR upper field)

Ports:
- CLK  in  1  system clock, all state updates on posedge
- RST_N  in  1  asynchronous active-low reset
- RUN  in  1  1 = execute ctrl_wrd; 0 = ctrl_wrd treated as all-zero
- ctrl_wrd  in  16  control word; bit15 HLT, 14 AI, 13 AO, 12 BI, 11 MI, 10 RR, 9 RW, 8 II, 7 IO, 6 CI, 5 CO, 4 CE, 3 ALUOPTION, 2 ALUO, 1 DI, 0 FL
- prog_we  in  1  RAM write strobe from loader
- prog_addr  in  ADDR_W  loader address
- prog_data  in  DATA_W  loader data
- command  out  OP_W  IR[7:4]
- bus  out  DATA_W  current internal bus value (debug)
- disp_out  out  DATA_W  display register
- a_out, b_out  out  DATA_W  A and B registers
- pc_out  out  ADDR_W  program counter
- flag_c, flag_z  out  1  carry / zero flags
- halted  out  1  sticky halt
- bus_err  out  1  sticky bus-contention error

Behaviour:
- **Reset (RST_N=0, asynchronous):** A, B, IR, disp_out = 0; PC, MAR = 0; flag_c, flag_z, halted, bus_err = 0. RAM contents are not reset.
- **Effective control word:** eff = (RUN && !halted) ? ctrl_wrd : 0. All actions below use eff sampled at posedge CLK. Registers load the bus value present before that edge, so there is 1-cycle latency from ctrl_wrd to the register update.
- **Bus drivers (combinational):**
  - AO → A
  - RR → RAM[MAR], asynchronous read
  - IO → {0, IR[3:0]}
  - CO → {0, PC}
  - ALUO → alu[7:0]
- **Bus contention:**
  - No driver active → bus = 0.
  - More than one driver active → bus = 0 and bus_err is set on that edge.
  - bus_err stays set until reset.
- **Register loads:**
  - AI: A ← bus
  - BI: B ← bus
  - MI: MAR ← bus[ADDR_W-1:0]
  - II: IR ← bus
  - DI: disp_out ← bus
  - RW: RAM[MAR] ← bus
- **PC:**
  - CI: PC ← bus[ADDR_W-1:0].
  - Otherwise, CE: PC ← PC+1, wrapping 15 → 0.
  - CI and CE together: CI wins.
- **ALU:**
  - ALUOPTION=0: sum9 = A + B.
  - ALUOPTION=1: sum9 = A + ~B + 1.
  - alu = sum9[7:0].
  - On FL: flag_c ← sum9[8] (for subtract, 1 means no borrow); flag_z ← (alu == 0).
  - Flags are unchanged without FL.
- **Simultaneous load and drive:** a register may both drive and load in the same cycle (e.g. ALUO|AI). It loads the pre-edge bus value, so ALUO|AI gives A ← A+B exactly once per edge.
- **HLT:** halted ← 1 on the edge where eff.HLT=1; other bits in that same word still execute. halted clears only on reset.
- **Program load:**
  - prog_we is honoured only when RUN=0 or halted=1: RAM[prog_addr] ← prog_data.
  - prog_we is ignored while running.
  - If prog_we and eff.RW could coincide, prog_we has priority; by the gating rule they cannot.
- **command:** continuous IR[7:4], reflecting the IR value after the II edge.

Test Plan:
- **Reset:** drive RST_N low mid-cycle with A=0x5A, PC=7 → all outputs 0 immediately (asynchronous); RAM word written earlier is still readable after reset.
- **Fetch + LDA:** load RAM[0]=0x13, RAM[3]=0x42; run CO|MI, RR|II|CE, IO|MI, RR|AI → IR=0x13, command=1, PC=1, a_out=0x42 after the 4th edge.
- **ADD/SUB with flags:**
  - A=0xF0, B=0x20, ALUO|AI|FL → A=0x10, flag_c=1, flag_z=0.
  - Then B=0x10, ALUOPTION|ALUO|AI|FL → A=0x00, flag_c=1, flag_z=1.
- **PC boundary:** PC=15, CE → PC=0. IR=0x85, IO|CI|CE → PC=5 (CI wins).
- **Contention and halt:**
  - AO|CO → bus=0, bus_err=1 and stays 1.
  - HLT|AO|DI → disp_out=A, halted=1; subsequent AI words do not change A.
  - prog_we while halted writes RAM.
- **RUN gating:** RUN=0 with ctrl_wrd=AI|AO → no register change, no bus_err.
